key_matrix_scanner: RTL
=======================

KEY_MATRIX_SCANNER -- requirements
Module: key_matrix_scanner

Interface
REQ-001 SHALL have parameter ROW_INTERVAL, default 27000 (1 ms at 27 MHz): clock cycles each row is driven.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 540 (20 us): cycles after a row switch before columns are sampled; legal range 2..ROW_INTERVAL-2.
REQ-003 SHALL have parameter DEBOUNCE_SCANS, default 4: consecutive differing samples needed to confirm a change; legal range 2..15.
REQ-004 SHALL have port clock, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-006 SHALL have port row, output, 8: one-hot active-high row drive.
REQ-007 SHALL have port col, input, 8: asynchronous column sense; 1 means pressed on the driven row.
REQ-008 SHALL have port event_valid, output, 1: key event available.
REQ-009 SHALL have port event_ready, input, 1: consumer accepts the event.
REQ-010 SHALL have ports event_row (3 bits), event_col (3 bits) and event_pressed (1 bit), all outputs: event key index and direction (1 = press, 0 = release).
REQ-011 SHALL have port key_state, output, 64: debounced state, bit index row*8+col.

Function
REQ-012 SHALL pass col through a 2-flop synchronizer before any use.
REQ-013 SHALL drive row = row_reg at all times; row_reg rotates left (bit7 -> bit0) on advance.
REQ-014 SHALL run a row counter 0..ROW_INTERVAL-1 and sample the synchronized col into a raw register when the counter == SETTLE_CYCLES.
REQ-015 SHALL implement FSM SCAN -> PROCESS -> (EMIT <-> PROCESS) -> SCAN, entering PROCESS on the cycle after the sample.
REQ-016 SHALL in PROCESS evaluate one column per cycle, col 0..7 ascending, for the current row.
REQ-017 SHALL per key: raw == state clears the debounce count; raw != state increments it; the change is confirmed when the count reaches DEBOUNCE_SCANS-1 (the DEBOUNCE_SCANS-th consecutive differing sample).
REQ-018 SHALL on confirmation toggle the key_state bit, clear the count, load event fields and enter EMIT with event_valid=1.
REQ-019 SHALL hold event fields stable while event_valid=1 and event_ready=0; the transfer completes on the cycle where both are 1.
REQ-020 SHALL after transfer resume PROCESS at the next column, or return to SCAN after col 7.
REQ-021 SHALL advance row_reg and clear the counter only when counter == ROW_INTERVAL-1 and FSM is in SCAN; otherwise the counter holds at ROW_INTERVAL-1 (backpressure stalls scanning, no event is ever dropped).
REQ-022 SHALL process simultaneous changes on several columns of one row as separate events in ascending column order.
REQ-023 SHALL report a key bouncing back before confirmation as no event and clear its count.

Reset
REQ-024 SHALL on reset set row_reg=8'b0000_0001, counter=0, FSM=SCAN, key_state=0, all debounce counts=0, synchronizer=0 and event_valid=0; event_row/col/pressed=0.
REQ-025 SHALL on reset asserted mid-EMIT drop the pending event on the next edge, with no recovery of it.

Configuration
REQ-026 SHALL use macro KEY_MATRIX_DEBOUNCE_EN: when defined, debouncing per REQ-017.
REQ-027 SHALL, with KEY_MATRIX_DEBOUNCE_EN undefined, confirm any raw != state immediately, omit the debounce counters and ignore DEBOUNCE_SCANS.

Verification (ROW_INTERVAL=16, SETTLE_CYCLES=4, DEBOUNCE_SCANS=3, macro defined unless noted)
REQ-028 SHALL check: after reset, no press -> row sequence 01,02,04..80,01, each held 16 cycles, and event_valid is never 1.
REQ-029 SHALL check: hold row2/col5 pressed for 3 scans with event_ready=1 -> exactly one event (row=2, col=5, pressed=1) and key_state[21]=1; release it -> one event with pressed=0.
REQ-030 SHALL check: press row0/col3 for only 2 scans, then release -> no event, key_state[3] stays 0.
REQ-031 SHALL check: row4 cols 1 and 6 pressed together, event_ready=0 for 50 cycles -> event (4,1,1) held stable, row stays 8'h10; after ready, (4,6,1) follows, then scanning resumes.
REQ-032 SHALL check: macro undefined, press row7/col0 for one scan -> event (7,0,1) after that single scan.
REQ-033 SHALL check: reset asserted during a pending event -> the next cycle has event_valid=0, row=01 and key_state=0.

Source files
------------

// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner: 8x8 key matrix scanner with per-key debouncing and a
// valid/ready event stream.
//
// Configuration macro: KEY_MATRIX_DEBOUNCE_EN
//   defined   - a change must be seen on DEBOUNCE_SCANS consecutive scans
//   undefined - any raw/state difference is confirmed on the first scan;
//               no debounce counters are built and DEBOUNCE_SCANS is unused
//
// Ports:
//   clock         - single clock, rising edge
//   reset         - synchronous active-high reset
//   row[7:0]      - one-hot active-high row drive
//   col[7:0]      - asynchronous column sense, 1 = pressed on driven row
//   event_valid   - key event available
//   event_ready   - consumer accepts the event
//   event_row     - row index of the event key
//   event_col     - column index of the event key
//   event_pressed - 1 = press, 0 = release
//   key_state     - debounced key state, bit index row*8+col
module key_matrix_scanner #(
    parameter int unsigned ROW_INTERVAL   = 27000,
    parameter int unsigned SETTLE_CYCLES  = 540,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic [7:0]  row,
    input  logic [7:0]  col,
    output logic        event_valid,
    input  logic        event_ready,
    output logic [2:0]  event_row,
    output logic [2:0]  event_col,
    output logic        event_pressed,
    output logic [63:0] key_state
);

    localparam int unsigned CntW = (ROW_INTERVAL > 1) ? $clog2(ROW_INTERVAL) : 1;
    localparam logic [CntW-1:0] CntLast   = CntW'(ROW_INTERVAL - 1);
    localparam logic [CntW-1:0] CntSample = CntW'(SETTLE_CYCLES);

    if (SETTLE_CYCLES < 2 || SETTLE_CYCLES + 2 > ROW_INTERVAL) begin : g_bad_settle
        $error("SETTLE_CYCLES must lie in 2..ROW_INTERVAL-2");
    end
    if (DEBOUNCE_SCANS < 2 || DEBOUNCE_SCANS > 15) begin : g_bad_debounce
        $error("DEBOUNCE_SCANS must lie in 2..15");
    end

    typedef enum logic [1:0] {StScan, StProcess, StEmit} state_e;

    logic [7:0]      col_meta_q, col_sync_q;
    logic [7:0]      row_q;
    logic [CntW-1:0] cnt_q;
    logic [7:0]      raw_q;
    state_e          state_q;
    logic [2:0]      col_idx_q;
    logic [63:0]     key_state_q;
    logic            ev_valid_q;
    logic [2:0]      ev_row_q, ev_col_q;
    logic            ev_pressed_q;

    logic [2:0] row_idx;
    logic [5:0] key_idx;
    logic       raw_bit, cur_bit, differ, confirm;

    // Row stays put outside StScan, so the encoded index is stable while processing.
    always_comb begin
        row_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (row_q[i]) row_idx = 3'(i);
        end
    end

    assign key_idx = {row_idx, col_idx_q};
    assign raw_bit = raw_q[col_idx_q];
    assign cur_bit = key_state_q[key_idx];
    assign differ  = raw_bit ^ cur_bit;

`ifdef KEY_MATRIX_DEBOUNCE_EN
    logic [3:0] deb_q [64];

    // The DEBOUNCE_SCANS-th consecutive differing sample confirms the change.
    assign confirm = differ && (deb_q[key_idx] == 4'(DEBOUNCE_SCANS - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) deb_q[i] <= '0;
        end else if (state_q == StProcess) begin
            if (!differ || confirm) deb_q[key_idx] <= '0;
            else                    deb_q[key_idx] <= deb_q[key_idx] + 4'd1;
        end
    end
`else
    assign confirm = differ;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            col_meta_q <= '0;
            col_sync_q <= '0;
        end else begin
            col_meta_q <= col;
            col_sync_q <= col_meta_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row_q        <= 8'b0000_0001;
            cnt_q        <= '0;
            raw_q        <= '0;
            state_q      <= StScan;
            col_idx_q    <= '0;
            key_state_q  <= '0;
            ev_valid_q   <= 1'b0;
            ev_row_q     <= '0;
            ev_col_q     <= '0;
            ev_pressed_q <= 1'b0;
        end else begin
            // Counter parks at its last value until the FSM is back in StScan,
            // so a stalled consumer holds the current row rather than losing events.
            if (cnt_q == CntLast) begin
                if (state_q == StScan) begin
                    cnt_q <= '0;
                    row_q <= {row_q[6:0], row_q[7]};
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            unique case (state_q)
                StScan: begin
                    if (cnt_q == CntSample) begin
                        raw_q     <= col_sync_q;
                        col_idx_q <= '0;
                        state_q   <= StProcess;
                    end
                end
                StProcess: begin
                    if (confirm) begin
                        key_state_q[key_idx] <= ~cur_bit;
                        ev_row_q             <= row_idx;
                        ev_col_q             <= col_idx_q;
                        ev_pressed_q         <= raw_bit;
                        ev_valid_q           <= 1'b1;
                        state_q              <= StEmit;
                    end else if (col_idx_q == 3'd7) begin
                        state_q <= StScan;
                    end else begin
                        col_idx_q <= col_idx_q + 3'd1;
                    end
                end
                StEmit: begin
                    if (event_ready) begin
                        ev_valid_q <= 1'b0;
                        if (col_idx_q == 3'd7) begin
                            state_q <= StScan;
                        end else begin
                            col_idx_q <= col_idx_q + 3'd1;
                            state_q   <= StProcess;
                        end
                    end
                end
                default: state_q <= StScan;
            endcase
        end
    end

    assign row           = row_q;
    assign event_valid   = ev_valid_q;
    assign event_row     = ev_row_q;
    assign event_col     = ev_col_q;
    assign event_pressed = ev_pressed_q;
    assign key_state     = key_state_q;

endmodule
